// File: rtl/turnstile_credit_fsm_if.sv
// Coin/push inputs and lock/credit/event outputs of the turnstile credit controller.
// The slave modport is the controller side, and the master modport is the environment side.
interface turnstile_credit_fsm_if #(
    parameter int CREDIT_W = 3
);
    logic                i_Coin;
    logic                i_Push;
    logic                o_Locked;
    logic [CREDIT_W-1:0] o_Credit;
    logic                o_Entry;
    logic                o_Coin_Reject;
    logic                o_Timeout;
    logic                o_Alarm;

    modport slave (
        input  i_Coin,
        input  i_Push,
        output o_Locked,
        output o_Credit,
        output o_Entry,
        output o_Coin_Reject,
        output o_Timeout,
        output o_Alarm
    );

    modport master (
        output i_Coin,
        output i_Push,
        input  o_Locked,
        input  o_Credit,
        input  o_Entry,
        input  o_Coin_Reject,
        input  o_Timeout,
        input  o_Alarm
    );
endinterface

// File: rtl/turnstile_credit_fsm.sv
// Credit-accumulating turnstile lock controller with fare, saturation ceiling and optional relock timeout.
// Optional forced-entry alarm is enabled by defining TURNSTILE_ALARM_EN.
module turnstile_credit_fsm #(
    parameter int PRICE          = 2,
    parameter int MAX_CREDIT     = 7,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic                   i_Clk,
    input logic                   i_Reset,
    turnstile_credit_fsm_if.slave if_Bus
);
    localparam int CREDIT_W = $clog2(MAX_CREDIT + 1);
    localparam int TMR_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] MAX_C   = CREDIT_W'(MAX_CREDIT);
    localparam logic [TMR_W-1:0]    TMO_C   = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0]    TMR_ONE = TMR_W'(1);

    typedef enum logic {
        ST_LOCKED   = 1'b0,
        ST_UNLOCKED = 1'b1
    } state_t;

    state_t              r_State;
    logic                r_Locked;
    logic [CREDIT_W-1:0] r_Credit;
    logic [TMR_W-1:0]    r_Timer;
    logic                r_Prev_Coin;
    logic                r_Prev_Push;
    logic                r_Entry;
    logic                r_Coin_Reject;
    logic                r_Timeout;

    logic                w_Coin_Edge;
    logic                w_Push_Edge;
    logic                w_Full;
    logic [CREDIT_W-1:0] w_Credit_Plus;

    assign w_Coin_Edge   = if_Bus.i_Coin & ~r_Prev_Coin;
    assign w_Push_Edge   = if_Bus.i_Push & ~r_Prev_Push;
    assign w_Full        = (r_Credit == MAX_C);
    // A coin at the ceiling is rejected rather than banked, so the sum never wraps.
    assign w_Credit_Plus = r_Credit + CREDIT_W'(w_Coin_Edge & ~w_Full);

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_State       <= ST_LOCKED;
            r_Locked      <= 1'b1;
            r_Credit      <= '0;
            r_Timer       <= '0;
            r_Prev_Coin   <= 1'b0;
            r_Prev_Push   <= 1'b0;
            r_Entry       <= 1'b0;
            r_Coin_Reject <= 1'b0;
            r_Timeout     <= 1'b0;
        end else begin
            r_Prev_Coin   <= if_Bus.i_Coin;
            r_Prev_Push   <= if_Bus.i_Push;
            r_Entry       <= 1'b0;
            r_Timeout     <= 1'b0;
            r_Coin_Reject <= w_Coin_Edge & w_Full;
            case (r_State)
                ST_LOCKED: begin
                    // Banked credit alone is enough to unlock; push is not a trigger here.
                    if (w_Credit_Plus >= PRICE_C) begin
                        r_State  <= ST_UNLOCKED;
                        r_Locked <= 1'b0;
                        r_Credit <= w_Credit_Plus - PRICE_C;
                        r_Timer  <= TMO_C;
                    end else begin
                        r_Credit <= w_Credit_Plus;
                    end
                end
                ST_UNLOCKED: begin
                    r_Credit <= w_Credit_Plus;
                    if (w_Push_Edge) begin
                        r_State  <= ST_LOCKED;
                        r_Locked <= 1'b1;
                        r_Entry  <= 1'b1;
                        r_Timer  <= '0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        // The fare is forfeited on timeout; nothing is refunded.
                        if (r_Timer == TMR_ONE) begin
                            r_State   <= ST_LOCKED;
                            r_Locked  <= 1'b1;
                            r_Timeout <= 1'b1;
                            r_Timer   <= '0;
                        end else begin
                            r_Timer <= r_Timer - TMR_ONE;
                        end
                    end
                end
                default: begin
                    r_State  <= ST_LOCKED;
                    r_Locked <= 1'b1;
                end
            endcase
        end
    end

`ifdef TURNSTILE_ALARM_EN
    logic r_Alarm;

    // Sticky until the next coin; a push that arrives together with a coin is not an attempt.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_Alarm <= 1'b0;
        end else if (w_Coin_Edge) begin
            r_Alarm <= 1'b0;
        end else if (w_Push_Edge && (r_State == ST_LOCKED)) begin
            r_Alarm <= 1'b1;
        end
    end

    assign if_Bus.o_Alarm = r_Alarm;
`else
    assign if_Bus.o_Alarm = 1'b0;
`endif

    assign if_Bus.o_Locked      = r_Locked;
    assign if_Bus.o_Credit      = r_Credit;
    assign if_Bus.o_Entry       = r_Entry;
    assign if_Bus.o_Coin_Reject = r_Coin_Reject;
    assign if_Bus.o_Timeout     = r_Timeout;

endmodule

// File: tb/tb_turnstile_credit_fsm.sv
// Directed bench for turnstile_credit_fsm at PRICE=2, MAX_CREDIT=5, TIMEOUT_CYCLES=8.
// Each tick drives the inputs just after a rising edge, so the next edge samples them and outputs are checked 1 time unit later.
module tb_turnstile_credit_fsm;
    localparam int PRICE    = 2;
    localparam int MAXC     = 5;
    localparam int TMO      = 8;
    localparam int CREDIT_W = $clog2(MAXC + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    turnstile_credit_fsm_if #(.CREDIT_W(CREDIT_W)) u_if ();

    turnstile_credit_fsm #(
        .PRICE(PRICE),
        .MAX_CREDIT(MAXC),
        .TIMEOUT_CYCLES(TMO)
    ) u_dut (
        .i_Clk  (clk),
        .i_Reset(rst),
        .if_Bus (u_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic l, input int c,
                           input logic e, input logic r, input logic t);
        chk({tag, ".locked"}, 32'(u_if.o_Locked), 32'(l));
        chk({tag, ".credit"}, 32'(u_if.o_Credit), 32'(c));
        chk({tag, ".entry"}, 32'(u_if.o_Entry), 32'(e));
        chk({tag, ".reject"}, 32'(u_if.o_Coin_Reject), 32'(r));
        chk({tag, ".timeout"}, 32'(u_if.o_Timeout), 32'(t));
    endtask

    task automatic tick(input logic c, input logic p);
        u_if.i_Coin = c;
        u_if.i_Push = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        u_if.i_Coin = 1'b0;
        u_if.i_Push = 1'b0;

        // Reset held for five cycles, then released
        repeat (5) @(posedge clk);
        #1;
        chk_all("rst_held", 1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("rst_held.alarm", 32'(u_if.o_Alarm), 32'd0);
        rst = 1'b0;
        tick(0, 0);
        chk_all("rst_rel", 1'b1, 0, 1'b0, 1'b0, 1'b0);

        // Two coins unlock, one push relocks
        tick(1, 0); chk_all("coin1", 1'b1, 1, 1'b0, 1'b0, 1'b0);
        tick(0, 0); chk_all("gap1", 1'b1, 1, 1'b0, 1'b0, 1'b0);
        tick(1, 0); chk_all("coin2", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        tick(0, 0); chk_all("unl_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        tick(0, 1); chk_all("push", 1'b1, 0, 1'b1, 1'b0, 1'b0);
        tick(0, 0); chk_all("push_after", 1'b1, 0, 1'b0, 1'b0, 1'b0);

        // Held coin level banks only once
        tick(1, 0); chk_all("hold_a", 1'b1, 1, 1'b0, 1'b0, 1'b0);
        tick(1, 0); chk_all("hold_b", 1'b1, 1, 1'b0, 1'b0, 1'b0);
        tick(0, 0);

        // Unlock (E0), then bank coins through one timeout and up to the ceiling
        tick(1, 0); chk_all("e0_unlock", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        tick(0, 0);
        tick(1, 0); chk_all("e2", 1'b0, 1, 1'b0, 1'b0, 1'b0);
        tick(0, 0);
        tick(1, 0); chk_all("e4", 1'b0, 2, 1'b0, 1'b0, 1'b0);
        tick(0, 0);
        tick(1, 0); chk_all("e6", 1'b0, 3, 1'b0, 1'b0, 1'b0);
        tick(0, 0); chk_all("e7", 1'b0, 3, 1'b0, 1'b0, 1'b0);
        tick(1, 0); chk_all("e8_tmo_coin", 1'b1, 4, 1'b0, 1'b0, 1'b1);
        tick(0, 0); chk_all("e9_autounl", 1'b0, 2, 1'b0, 1'b0, 1'b0);
        tick(1, 0); chk_all("e10", 1'b0, 3, 1'b0, 1'b0, 1'b0);
        tick(0, 0);
        tick(1, 0); chk_all("e12", 1'b0, 4, 1'b0, 1'b0, 1'b0);
        tick(0, 0);
        tick(1, 0); chk_all("e14", 1'b0, 5, 1'b0, 1'b0, 1'b0);
        tick(0, 0);
        tick(1, 0); chk_all("e16_reject", 1'b0, 5, 1'b0, 1'b1, 1'b0);
        tick(0, 1); chk_all("e17_push_wins", 1'b1, 5, 1'b1, 1'b0, 1'b0);
        tick(0, 0); chk_all("e18_autounl", 1'b0, 3, 1'b0, 1'b0, 1'b0);

        // Bring credit down, then let the timer run out
        tick(0, 1); chk_all("e19_push", 1'b1, 3, 1'b1, 1'b0, 1'b0);
        tick(0, 0); chk_all("e20_autounl", 1'b0, 1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            tick(0, 0);
            chk("tmo_wait.locked", 32'(u_if.o_Locked), 32'd0);
            chk("tmo_wait.timeout", 32'(u_if.o_Timeout), 32'd0);
        end
        tick(0, 0); chk_all("e28_timeout", 1'b1, 1, 1'b0, 1'b0, 1'b1);
        tick(0, 0); chk_all("e29_after", 1'b1, 1, 1'b0, 1'b0, 1'b0);

        // Unlock again and push exactly on the expiry cycle
        tick(1, 0); chk_all("e30_unlock", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            tick(0, 0);
        end
        chk_all("e37", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        tick(0, 1); chk_all("e38_push_expiry", 1'b1, 0, 1'b1, 1'b0, 1'b0);
        tick(0, 0); chk_all("e39", 1'b1, 0, 1'b0, 1'b0, 1'b0);

        // Coin and push on the same edge while unlocked with zero credit
        tick(1, 0);
        tick(0, 0);
        tick(1, 0); chk_all("e42_unlock", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        tick(0, 0);
        tick(1, 1); chk_all("e44_coin_push", 1'b1, 1, 1'b1, 1'b0, 1'b0);
        tick(0, 0); chk_all("e45", 1'b1, 1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with credit 1 in UNLOCKED
        tick(1, 0); chk_all("e46_unlock", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        tick(0, 0);
        tick(1, 0); chk_all("e48_credit1", 1'b0, 1, 1'b0, 1'b0, 1'b0);
        u_if.i_Coin = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b1, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(0, 0); chk_all("rst2_rel", 1'b1, 0, 1'b0, 1'b0, 1'b0);

`ifdef TURNSTILE_ALARM_EN
        tick(0, 1); chk("alarm_set", 32'(u_if.o_Alarm), 32'd1);
        chk("alarm_set.locked", 32'(u_if.o_Locked), 32'd1);
        tick(0, 0); chk("alarm_sticky", 32'(u_if.o_Alarm), 32'd1);
        tick(1, 0); chk("alarm_clear", 32'(u_if.o_Alarm), 32'd0);
        chk("alarm_clear.credit", 32'(u_if.o_Credit), 32'd1);
        tick(0, 0);
        tick(1, 1); chk("alarm_coinpush", 32'(u_if.o_Alarm), 32'd0);
        chk("alarm_coinpush.locked", 32'(u_if.o_Locked), 32'd0);
`else
        tick(0, 1); chk("alarm_off", 32'(u_if.o_Alarm), 32'd0);
        chk("alarm_off.locked", 32'(u_if.o_Locked), 32'd1);
        tick(0, 0); chk("alarm_off2", 32'(u_if.o_Alarm), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
